// File: rtl/tx_framer_8b10b.sv
// tx_framer_8b10b: transmit framer and 8b/10b encoder for the chiplet PHY link.
// Sequences ACK / credit-grant commas and START, data, END packet words into
// a single registered output slot with a valid/ready handshake.
// Optional build macro TX_CTRL_PREEMPT_EN: when defined, pending ACK and
// GRTCRED requests are also served in SEND_DATA, taking the place of the
// next data flit.
// The packet length is taken from the header payload: expected_num_flits is
// payload[PKT_LENGTH_WIDTH-1:0]; a value of 0 is treated like 1.
module tx_framer_8b10b #(
  parameter int PORTCOUNT = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    flit_valid,
  input  logic [PORTCOUNT*8-1:0]  flit,
  output logic                    flit_ready,
  input  logic                    grtcred_valid,
  input  logic                    grtcred_vc,
  output logic                    grtcred_ready,
  input  logic                    ack_valid,
  input  logic [7:0]              ack_meta,
  output logic                    ack_ready,
  output logic [PORTCOUNT*10-1:0] enc_flit,
  output logic [1:0]              comma_length_sel,
  output logic                    enc_valid,
  input  logic                    enc_ready,
  output logic                    busy
);

  localparam int WORD_W           = PORTCOUNT * 10;
  localparam int PKT_LENGTH_WIDTH = 4;

  // Disparity-neutral K-codes, written as {abcdei, fghj}
  localparam logic [9:0] START_COMMA    = 10'b110110_1000; // K27.7
  localparam logic [9:0] END_COMMA      = 10'b101110_1000; // K29.7
  localparam logic [9:0] GRTCRED0_COMMA = 10'b001111_0100; // K28.0
  localparam logic [9:0] GRTCRED1_COMMA = 10'b001111_0010; // K28.4
  localparam logic [9:0] ACK_COMMA      = 10'b011110_1000; // K30.7

  localparam logic [1:0] SELECT_COMMA_1_FLIT = 2'd0;
  localparam logic [1:0] SELECT_COMMA_2_FLIT = 2'd1;
  localparam logic [1:0] SELECT_COMMA_DATA   = 2'd2;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SEND_START = 2'd1;
  localparam logic [1:0] SEND_DATA  = 2'd2;
  localparam logic [1:0] SEND_END   = 2'd3;

  localparam logic [PKT_LENGTH_WIDTH-1:0] REM_ZERO = '0;
  localparam logic [PKT_LENGTH_WIDTH-1:0] REM_ONE  = 1;

  // rd encoding: 0 = RD-, 1 = RD+. Returns {rd_out, abcdei, fghj}.
  function automatic logic [10:0] enc_8b10b(input logic [7:0] din, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       neut6;
    logic       neut4;
    logic       rd_mid;
    logic       alt7;
    x = din[4:0];
    y = din[7:5];
    // RD- column of the 5b/6b table
    case (x)
      5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;
      5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
      5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;
      5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
      5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;
      5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
      5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;
      5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
      5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;
      5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
      5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;
      5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
      5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;
      5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
      5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;
      5'd30: c6 = 6'b011110;  5'd31: c6 = 6'b101011;
      default: c6 = 6'b000000;
    endcase
    // Unbalanced codes (and D.07) use the complement under RD+
    neut6 = ($countones(c6) == 3);
    if (rd_in && (!neut6 || x == 5'd7)) c6 = ~c6;
    rd_mid = neut6 ? rd_in : ~rd_in;
    // D.x.A7 avoids a run of five identical bits across the sub-block seam
    alt7 = (y == 3'd7) &&
           ((!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
            ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    case (y)
      3'd0: c4 = 4'b1011;
      3'd1: c4 = 4'b1001;
      3'd2: c4 = 4'b0101;
      3'd3: c4 = 4'b1100;
      3'd4: c4 = 4'b1101;
      3'd5: c4 = 4'b1010;
      3'd6: c4 = 4'b0110;
      3'd7: c4 = alt7 ? 4'b0111 : 4'b1110;
      default: c4 = 4'b0000;
    endcase
    neut4 = ($countones(c4) == 2);
    if (rd_mid && (!neut4 || y == 3'd3)) c4 = ~c4;
    return {(neut4 ? rd_mid : ~rd_mid), c6, c4};
  endfunction

  function automatic logic [WORD_W-1:0] comma_word(input logic [9:0] k);
    logic [WORD_W-1:0] w;
    w = '0;
    w[9:0] = k;
    return w;
  endfunction

  logic [1:0]                  state_q, state_d;
  logic [PKT_LENGTH_WIDTH-1:0] remaining_q, remaining_d;
  logic                        rd_q, rd_d;
  logic                        enc_valid_q;
  logic [WORD_W-1:0]           enc_flit_q;
  logic [1:0]                  sel_q;

  logic                        slot_free;
  logic                        load;
  logic [WORD_W-1:0]           load_word;
  logic [1:0]                  load_sel;
  logic [WORD_W-1:0]           data_word;
  logic                        data_rd;
  logic [10:0]                 ack_enc;
  logic [WORD_W-1:0]           ack_word;
  logic [WORD_W-1:0]           grt_word;
  logic [PKT_LENGTH_WIDTH-1:0] hdr_len;
  logic [PKT_LENGTH_WIDTH-1:0] hdr_rem;
  logic [PKT_LENGTH_WIDTH-1:0] dec_rem;

  assign slot_free = !enc_valid_q || enc_ready;
  assign ack_enc   = enc_8b10b(ack_meta, rd_q);
  assign grt_word  = comma_word(grtcred_vc ? GRTCRED1_COMMA : GRTCRED0_COMMA);
  assign hdr_len   = flit[PKT_LENGTH_WIDTH-1:0];
  assign hdr_rem   = (hdr_len == REM_ZERO) ? REM_ZERO : hdr_len - REM_ONE;
  assign dec_rem   = (remaining_q == REM_ZERO) ? REM_ZERO : remaining_q - REM_ONE;

  // ACK word: comma in slice 1, encoded metadata byte in slice 0
  always_comb begin
    ack_word        = '0;
    ack_word[19:10] = ACK_COMMA;
    ack_word[9:0]   = ack_enc[9:0];
  end

  // Encode every byte of the offered flit, chaining disparity slice to slice
  always_comb begin
    logic [10:0] enc;
    data_word = '0;
    data_rd   = rd_q;
    for (int i = 0; i < PORTCOUNT; i++) begin
      enc                   = enc_8b10b(flit[i*8 +: 8], data_rd);
      data_word[i*10 +: 10] = enc[9:0];
      data_rd               = enc[10];
    end
  end

  // Sequencer: picks the next word for the output slot and drives the readies
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    rd_d          = rd_q;
    load          = 1'b0;
    load_word     = '0;
    load_sel      = SELECT_COMMA_1_FLIT;
    flit_ready    = 1'b0;
    grtcred_ready = 1'b0;
    ack_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        if (slot_free) begin
          if (ack_valid) begin
            ack_ready = 1'b1;
            load      = 1'b1;
            load_word = ack_word;
            load_sel  = SELECT_COMMA_2_FLIT;
            rd_d      = ack_enc[10];
          end else if (grtcred_valid) begin
            grtcred_ready = 1'b1;
            load          = 1'b1;
            load_word     = grt_word;
          end else if (flit_valid) begin
            // START goes out first; the header itself is taken next cycle
            load      = 1'b1;
            load_word = comma_word(START_COMMA);
            state_d   = SEND_START;
          end
        end
      end
      SEND_START: begin
        if (slot_free && flit_valid) begin
          flit_ready  = 1'b1;
          load        = 1'b1;
          load_word   = data_word;
          load_sel    = SELECT_COMMA_DATA;
          rd_d        = data_rd;
          remaining_d = hdr_rem;
          state_d     = (hdr_rem != REM_ZERO) ? SEND_DATA : SEND_END;
        end
      end
      SEND_DATA: begin
        if (slot_free) begin
`ifdef TX_CTRL_PREEMPT_EN
          if (ack_valid) begin
            ack_ready = 1'b1;
            load      = 1'b1;
            load_word = ack_word;
            load_sel  = SELECT_COMMA_2_FLIT;
            rd_d      = ack_enc[10];
          end else if (grtcred_valid) begin
            grtcred_ready = 1'b1;
            load          = 1'b1;
            load_word     = grt_word;
          end else
`endif
          if (flit_valid) begin
            flit_ready  = 1'b1;
            load        = 1'b1;
            load_word   = data_word;
            load_sel    = SELECT_COMMA_DATA;
            rd_d        = data_rd;
            remaining_d = dec_rem;
            if (dec_rem == REM_ZERO) state_d = SEND_END;
          end
        end
      end
      SEND_END: begin
        if (slot_free) begin
          load      = 1'b1;
          load_word = comma_word(END_COMMA);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slot and sequencer state; a word holds until the serializer takes it
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      remaining_q <= REM_ZERO;
      rd_q        <= 1'b0;
      enc_valid_q <= 1'b0;
      enc_flit_q  <= '0;
      sel_q       <= SELECT_COMMA_1_FLIT;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rd_q        <= rd_d;
      if (load) begin
        enc_valid_q <= 1'b1;
        enc_flit_q  <= load_word;
        sel_q       <= load_sel;
      end else if (enc_ready) begin
        enc_valid_q <= 1'b0;
      end
    end
  end

  assign enc_flit         = enc_flit_q;
  assign comma_length_sel = sel_q;
  assign enc_valid        = enc_valid_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: doc/tx_framer_8b10b.md
Name: tx_framer_8b10b

Overview:
- Transmit-side framer and 8b/10b encoder for the chiplet PHY link.
- Accepts flits, credit-grant requests and ACK requests from the link layer, then sequences them into encoded words: START comma, data flits, END comma, GRTCRED0/1 comma, ACK comma plus metadata byte.
- Each word is tagged with its comma_length_sel and driven to the serializer under a valid/ready handshake.

Parameters:
- PORTCOUNT, 5: bytes per flit. Encoded word width is PORTCOUNT*10; flit_t is PORTCOUNT*8 = 40 bits.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- flit_valid  in  1  upstream flit available
- flit  in  40  flit_t (metadata[7:0], payload[31:0])
- flit_ready  out  1  flit accepted this cycle when flit_valid & flit_ready
- grtcred_valid  in  1  credit-grant request
- grtcred_vc  in  1  0 selects GRTCRED0_COMMA, 1 selects GRTCRED1_COMMA
- grtcred_ready  out  1  credit grant accepted
- ack_valid  in  1  ACK request
- ack_meta  in  8  {vc, id[1:0], req[4:0]}
- ack_ready  out  1  ACK accepted
- enc_flit  out  PORTCOUNT*10  encoded word
- comma_length_sel  out  2  SELECT_COMMA_1_FLIT / SELECT_COMMA_2_FLIT / SELECT_COMMA_DATA
- enc_valid  out  1  enc_flit valid
- enc_ready  in  1  serializer consumes word when enc_valid & enc_ready
- busy  out  1  packet in progress (state != IDLE)

Behaviour:
- Reset (RST high at posedge): enc_valid=0, enc_flit=0, comma_length_sel=SELECT_COMMA_1_FLIT, state=IDLE, remaining=0, running disparity rd=RD-, busy=0. Reset mid-packet abandons the packet; no END is emitted.
- Output register:
  - A new word is loaded when !enc_valid | enc_ready ("slot free").
  - Latency is 1 cycle from acceptance to enc_valid.
  - enc_flit and comma_length_sel hold stable while enc_valid & !enc_ready.
  - Each *_ready is a combinational function of slot free, state and priority. At most one of flit/grtcred/ack is accepted per cycle.
- Word formats:
  - 1-flit comma: word[9:0]=comma constant from phy_types_pkg; upper slices = 0.
  - ACK: word[19:10]=ACK_COMMA; word[9:0]=8b/10b encoding of ack_meta using rd; other slices = 0; comma_length_sel=SELECT_COMMA_2_FLIT.
  - Data: byte i is encoded into word[i*10+:10]; comma_length_sel=SELECT_COMMA_DATA.
- Running disparity:
  - Slices are chained: slice 0 uses rd; slice i uses the rd_out of slice i-1.
  - rd updates on load to the last encoded slice's rd_out.
  - Comma words leave rd unchanged; comma constants are disparity-neutral.
- FSM states: IDLE, SEND_START, SEND_DATA, SEND_END.
  - IDLE, slot free, priority ACK > GRTCRED > packet:
    - ack_valid: emit ACK word.
    - Else grtcred_valid: emit GRTCRED comma.
    - Else flit_valid: emit START_COMMA (flit not yet accepted), go to SEND_START.
  - SEND_START: accept the header flit and emit it. remaining = expected_num_flits(flit.payload) - 1. Go to SEND_DATA if remaining != 0, else SEND_END.
  - SEND_DATA:
    - Accept a flit and emit it; remaining decrements.
    - When remaining reaches 0 after a load, go to SEND_END.
    - ACK/GRTCRED are not served in this state (see optional feature).
    - flit_valid low inserts no word; enc_valid drops once the slot drains.
  - SEND_END: emit END_COMMA, go to IDLE. Back-to-back packets: the next START may load the cycle after END loads.
  - remaining width is PKT_LENGTH_WIDTH. Decrement saturates at 0; no wrap.
- Simultaneous events: ack_valid and grtcred_valid both high in IDLE serves ACK first, then GRTCRED next free slot, then START. Requests stay pending until their ready.

Optional Feature:
- TX_CTRL_PREEMPT_EN
- Defined: in SEND_DATA, a pending ack_valid or grtcred_valid (same priority) is emitted in place of the next data flit. flit_ready=0 that cycle; remaining unchanged. The receiver tolerates control commas mid-packet.
- Undefined: control commas only in IDLE, as above.

Test Plan:
- Reset, then send a header whose expected_num_flits=3 plus 2 more flits, with enc_ready=1 -> words START, DATA, DATA, DATA, END on consecutive cycles; busy low after END; each DATA slice decodes back to the sent byte.
- Hold enc_ready=0 for 4 cycles mid-packet -> enc_flit and comma_length_sel stable; flit_ready=0; no flit lost or duplicated.
- In IDLE: ack_valid with ack_meta=8'hA5, grtcred_valid with grtcred_vc=1, and flit_valid all high -> ACK (word[19:10]=ACK_COMMA, SELECT_COMMA_2_FLIT), then GRTCRED1_COMMA, then START.
- Header with expected_num_flits=1 -> START, DATA, END; remaining never underflows.
- Assert RST during SEND_DATA -> next cycle enc_valid=0, state IDLE, rd=RD-; next packet begins with START.
- With TX_CTRL_PREEMPT_EN, grtcred_valid (vc=0) raised mid-packet -> GRTCRED0_COMMA appears between data flits; total data flit count unchanged; END follows the last flit.
